// File: rtl/log_level_sequencer_if.sv
// Configuration-table ROM bus between the level sequencer (master) and the table ROM (slave).
interface log_level_sequencer_if;
    logic        cfg_rd_en;
    logic [4:0]  cfg_addr;
    logic [41:0] cfg_data;

    modport master (output cfg_rd_en, output cfg_addr, input cfg_data);
    modport slave  (input cfg_rd_en, input cfg_addr, output cfg_data);
endinterface

// File: rtl/log_level_sequencer.sv
// Loads per-level log-row configuration from the table ROM into shadow registers and
// commits it to the row outputs on a frame boundary, pulsing GoNextLevel on commit.
module log_level_sequencer #(
    parameter int NUM_ROWS   = 5,
    parameter int NUM_LEVELS = 4,
    parameter int MAX_SPEED  = 6
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk_rising_edge,
    input  logic                   level_up_req,
    input  logic                   restart_req,
    log_level_sequencer_if.master  cfg,
    output logic [NUM_ROWS*10-1:0] row_speed,
    output logic [NUM_ROWS*10-1:0] row_size_x,
    output logic [NUM_ROWS*40-1:0] row_offsets,
    output logic [NUM_ROWS-1:0]    row_dir,
    output logic [NUM_ROWS-1:0]    row_turtle,
    output logic [NUM_ROWS*2-1:0]  row_log_number,
    output logic                   GoNextLevel,
    output logic [1:0]             level,
    output logic                   busy
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_DRAIN      = 3'd2;
    localparam logic [2:0] S_WAIT_FRAME = 3'd3;
    localparam logic [2:0] S_COMMIT     = 3'd4;

    localparam logic [2:0] ROW_LAST  = 3'(NUM_ROWS - 1);
    localparam logic [1:0] LVL_LAST  = 2'(NUM_LEVELS - 1);
    localparam logic [4:0] SPEED_MAX = 5'(MAX_SPEED);

    logic [2:0] state;
    logic [2:0] row_idx;
    logic [1:0] target;
    logic [1:0] loop_count;
    logic       pending;
    logic       chained;
    logic       accept_up;
    logic       launch_next;

    logic       rd_en_p0;
    logic       cap_vld_p1;
    logic [2:0] cap_row_p1;
    logic [9:0] dec_speed_p1;
    logic [9:0] dec_size_p1;
    logic [39:0] dec_offs_p1;

    logic [NUM_ROWS*10-1:0] sh_speed;
    logic [NUM_ROWS*10-1:0] sh_size;
    logic [NUM_ROWS*40-1:0] sh_offs;
    logic [NUM_ROWS-1:0]    sh_dir;
    logic [NUM_ROWS-1:0]    sh_turtle;
    logic [NUM_ROWS*2-1:0]  sh_lognum;

    function automatic logic [9:0] sat_speed(input logic [3:0] spd, input logic [1:0] lc);
        logic [4:0] sum;
        sum = {1'b0, spd} + {3'b000, lc};
        if (sum > SPEED_MAX)
            sum = SPEED_MAX;
        return {5'b00000, sum};
    endfunction

    function automatic logic [9:0] size_x(input logic [1:0] code);
        logic [9:0] px;
        case (code)
            2'd0:    px = 10'd56;
            2'd1:    px = 10'd84;
            2'd2:    px = 10'd112;
            default: px = 10'd140;
        endcase
        return px;
    endfunction

    function automatic logic [9:0] offset_x2(input logic [7:0] b);
        return {1'b0, b, 1'b0};
    endfunction

    function automatic logic [1:0] level_inc(input logic [1:0] lvl);
        return (lvl == LVL_LAST) ? 2'd0 : lvl + 2'd1;
    endfunction

    // Loop count advances only when the level wraps, and sticks at 3.
    function automatic logic [1:0] loop_inc(input logic [1:0] lvl, input logic [1:0] lc);
        return (lvl == LVL_LAST && lc != 2'd3) ? lc + 2'd1 : lc;
    endfunction

    // A request is held only when nothing is pending and the current load was not itself
    // launched from a held request.
    assign accept_up   = level_up_req && !pending && !chained;
    assign launch_next = pending || accept_up;

    // Stage p0: ROM read issue
    assign rd_en_p0      = (state == S_LOAD) && !Reset;
    assign cfg.cfg_rd_en = rd_en_p0;
    assign cfg.cfg_addr  = {target, row_idx};
    assign busy          = (state != S_IDLE);

    // Stage p1: ROM data decode into shadow format
    assign dec_speed_p1 = sat_speed(cfg.cfg_data[41:38], loop_count);
    assign dec_size_p1  = size_x(cfg.cfg_data[33:32]);
    assign dec_offs_p1  = {offset_x2(cfg.cfg_data[31:24]), offset_x2(cfg.cfg_data[23:16]),
                           offset_x2(cfg.cfg_data[15:8]),  offset_x2(cfg.cfg_data[7:0])};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= S_LOAD;
            row_idx        <= '0;
            target         <= '0;
            loop_count     <= '0;
            pending        <= 1'b0;
            chained        <= 1'b0;
            cap_vld_p1     <= 1'b0;
            cap_row_p1     <= '0;
            sh_speed       <= '0;
            sh_size        <= '0;
            sh_offs        <= '0;
            sh_dir         <= '0;
            sh_turtle      <= '0;
            sh_lognum      <= '0;
            row_speed      <= '0;
            row_size_x     <= '0;
            row_offsets    <= '0;
            row_dir        <= '0;
            row_turtle     <= '0;
            row_log_number <= '0;
            level          <= '0;
            GoNextLevel    <= 1'b0;
        end else begin
            GoNextLevel <= 1'b0;
            cap_vld_p1  <= rd_en_p0;
            cap_row_p1  <= row_idx;

            for (int r = 0; r < NUM_ROWS; r++) begin
                if (cap_vld_p1 && cap_row_p1 == 3'(r)) begin
                    sh_speed[r*10 +: 10] <= dec_speed_p1;
                    sh_size[r*10 +: 10]  <= dec_size_p1;
                    sh_offs[r*40 +: 40]  <= dec_offs_p1;
                    sh_dir[r]            <= cfg.cfg_data[37];
                    sh_turtle[r]         <= cfg.cfg_data[36];
                    sh_lognum[r*2 +: 2]  <= cfg.cfg_data[35:34];
                end
            end

            case (state)
                S_IDLE: begin
                    if (level_up_req) begin
                        target     <= level_inc(level);
                        loop_count <= loop_inc(level, loop_count);
                        row_idx    <= '0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept_up)
                        pending <= 1'b1;
                    row_idx <= row_idx + 3'd1;
                    if (row_idx == ROW_LAST)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (accept_up)
                        pending <= 1'b1;
                    state <= S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (accept_up)
                        pending <= 1'b1;
                    // Active registers load on the edge entering COMMIT so the rows see the
                    // new configuration in the same cycle as GoNextLevel.
                    if (frame_clk_rising_edge && !restart_req) begin
                        row_speed      <= sh_speed;
                        row_size_x     <= sh_size;
                        row_offsets    <= sh_offs;
                        row_dir        <= sh_dir;
                        row_turtle     <= sh_turtle;
                        row_log_number <= sh_lognum;
                        level          <= target;
                        GoNextLevel    <= 1'b1;
                        state          <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (launch_next) begin
                        pending    <= 1'b0;
                        chained    <= 1'b1;
                        target     <= level_inc(level);
                        loop_count <= loop_inc(level, loop_count);
                        row_idx    <= '0;
                        state      <= S_LOAD;
                    end else begin
                        chained <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Restart overrides everything: discard any partial load and reload level 0.
            if (restart_req) begin
                target     <= '0;
                loop_count <= '0;
                pending    <= 1'b0;
                chained    <= 1'b0;
                row_idx    <= '0;
                state      <= S_LOAD;
                cap_vld_p1 <= 1'b0;
                sh_speed   <= '0;
                sh_size    <= '0;
                sh_offs    <= '0;
                sh_dir     <= '0;
                sh_turtle  <= '0;
                sh_lognum  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_log_level_sequencer.sv
// Scoreboard bench for log_level_sequencer: stimulus pushes expected commits, a monitor checks them.
`timescale 1ns/1ps
module tb_log_level_sequencer;
    typedef struct {
        logic [1:0]   level;
        logic [49:0]  speed;
        logic [49:0]  size;
        logic [199:0] offs;
        logic [4:0]   dir;
        logic [4:0]   turtle;
        logic [9:0]   lognum;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk_rising_edge = 1'b0;
    logic level_up_req = 1'b0;
    logic restart_req = 1'b0;
    logic [49:0]  row_speed;
    logic [49:0]  row_size_x;
    logic [199:0] row_offsets;
    logic [4:0]   row_dir;
    logic [4:0]   row_turtle;
    logic [9:0]   row_log_number;
    logic         GoNextLevel;
    logic [1:0]   level;
    logic         busy;

    log_level_sequencer_if bus();

    log_level_sequencer #(.NUM_ROWS(5), .NUM_LEVELS(4), .MAX_SPEED(6)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame_clk_rising_edge),
        .level_up_req(level_up_req), .restart_req(restart_req), .cfg(bus),
        .row_speed(row_speed), .row_size_x(row_size_x), .row_offsets(row_offsets),
        .row_dir(row_dir), .row_turtle(row_turtle), .row_log_number(row_log_number),
        .GoNextLevel(GoNextLevel), .level(level), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    logic [41:0] rom [0:31];

    always @(posedge Clk) if (bus.cfg_rd_en) bus.cfg_data <= rom[bus.cfg_addr];

    // Hand-chosen table: level 0 row 0 = speed 2, dir 1, turtle 0, log 1, size 2, bytes {0,40,80,120}
    function automatic int f_spd(input int L, input int R);  return (R*4 + L + 2) % 10; endfunction
    function automatic int f_dir(input int L, input int R);  return ((L + R) % 2 == 0) ? 1 : 0; endfunction
    function automatic int f_tur(input int L, input int R);  return R % 2; endfunction
    function automatic int f_log(input int L, input int R);  return (R + 1 + L) % 4; endfunction
    function automatic int f_code(input int L, input int R); return (R + 2 + L) % 4; endfunction
    function automatic int f_byte(input int L, input int R, input int k); return k*40 + R*8 + L*3; endfunction

    function automatic exp_t exp_for(input int L, input int lc);
        exp_t e;
        int s;
        e.level = 2'(L);
        for (int r = 0; r < 5; r++) begin
            s = f_spd(L, r) + lc;
            if (s > 6) s = 6;
            e.speed[r*10 +: 10] = 10'(s);
            e.size[r*10 +: 10]  = 10'(56 + 28*f_code(L, r));
            for (int k = 0; k < 4; k++)
                e.offs[r*40 + k*10 +: 10] = 10'(2*f_byte(L, r, k));
            e.dir[r]            = 1'(f_dir(L, r));
            e.turtle[r]         = 1'(f_tur(L, r));
            e.lognum[r*2 +: 2]  = 2'(f_log(L, r));
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops on every commit and guards output stability between commits
    exp_t        mon_e;
    logic [321:0] mon_cur;
    logic [321:0] snap = '0;
    logic        prev_gnl = 1'b0;
    logic        rst_d = 1'b1;
    always @(negedge Clk) begin
        mon_cur = {level, row_speed, row_size_x, row_offsets, row_dir, row_turtle, row_log_number};
        if (!Reset && GoNextLevel) begin
            chk("gnl_single_cycle", {255'd0, prev_gnl}, 256'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit: actual level=%0d required=no commit", level);
            end else begin
                mon_e = sb.pop_front();
                chk("commit_level",  level,          mon_e.level);
                chk("commit_speed",  row_speed,      mon_e.speed);
                chk("commit_size",   row_size_x,     mon_e.size);
                chk("commit_offs",   row_offsets,    mon_e.offs);
                chk("commit_dir",    row_dir,        mon_e.dir);
                chk("commit_turtle", row_turtle,     mon_e.turtle);
                chk("commit_lognum", row_log_number, mon_e.lognum);
            end
        end else if (!Reset && !rst_d) begin
            chk("stable_outputs", mon_cur, snap);
        end
        snap     <= mon_cur;
        prev_gnl <= GoNextLevel;
        rst_d    <= Reset;
    end

    task automatic pulse_up();
        @(negedge Clk) level_up_req = 1'b1;
        @(negedge Clk) level_up_req = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge Clk) restart_req = 1'b1;
        @(negedge Clk) restart_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge Clk);
            k++;
        end
        chk(nm, {255'd0, busy}, 256'd0);
    endtask

    task automatic frame_commit();
        @(negedge Clk) frame_clk_rising_edge = 1'b1;
        @(negedge Clk) frame_clk_rising_edge = 1'b0;
        wait_idle("idle_after_commit");
    endtask

    task automatic level_step(input int L, input int lc);
        sb.push_back(exp_for(L, lc));
        pulse_up();
        repeat (7) @(negedge Clk);
        chk("busy_in_wait_frame", {255'd0, busy}, 256'd1);
        frame_commit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] w;
        for (int L = 0; L < 4; L++)
            for (int R = 0; R < 8; R++) begin
                w = '0;
                if (R < 5) begin
                    w[41:38] = 4'(f_spd(L, R));
                    w[37]    = 1'(f_dir(L, R));
                    w[36]    = 1'(f_tur(L, R));
                    w[35:34] = 2'(f_log(L, R));
                    w[33:32] = 2'(f_code(L, R));
                    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(f_byte(L, R, k));
                end
                rom[L*8 + R] = w;
            end

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_gnl",       {255'd0, GoNextLevel},   256'd0);
        chk("rst_level",     level,                   256'd0);
        chk("rst_rd_en",     {255'd0, bus.cfg_rd_en}, 256'd0);
        chk("rst_row_speed", row_speed,               256'd0);
        chk("rst_offsets",   row_offsets,             256'd0);

        // Automatic level-0 load after reset: addresses 0..4 on consecutive cycles
        sb.push_back(exp_for(0, 0));
        Reset = 1'b0;
        #1;
        chk("boot_rd_en", {255'd0, bus.cfg_rd_en}, 256'd1);
        chk("boot_addr0", bus.cfg_addr, 256'd0);
        for (int i = 1; i < 5; i++) begin
            @(negedge Clk);
            chk("boot_rd_en", {255'd0, bus.cfg_rd_en}, 256'd1);
            chk("boot_addr",  bus.cfg_addr, 256'(i));
        end
        @(negedge Clk);
        chk("drain_rd_en", {255'd0, bus.cfg_rd_en}, 256'd0);

        // Frame held low for 1000 cycles: nothing commits
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            chk("hold_busy", {255'd0, busy},        256'd1);
            chk("hold_gnl",  {255'd0, GoNextLevel}, 256'd0);
        end
        frame_commit();
        chk("l0_row0_speed",  row_speed[9:0],       256'd2);
        chk("l0_row0_size",   row_size_x[9:0],      256'd112);
        chk("l0_row0_offs",   row_offsets[39:0],    {216'd0, 10'd240, 10'd160, 10'd80, 10'd0});
        chk("l0_row0_lognum", row_log_number[1:0],  256'd1);
        chk("l0_row0_dir",    {255'd0, row_dir[0]}, 256'd1);
        chk("l0_row1_size",   row_size_x[19:10],    256'd140);
        chk("l0_level",       level,                256'd0);

        // Walk levels through four wraps; loop count saturates at 3
        for (int i = 1; i <= 16; i++) begin
            level_step(i % 4, (i / 4 > 3) ? 3 : i / 4);
            if (i == 4) begin
                chk("wrap1_level",      level,              256'd0);
                chk("wrap1_row0_speed", row_speed[9:0],     256'd3);
                chk("wrap1_row1_speed", row_speed[19:10],   256'd6);
            end
            if (i == 12) begin
                chk("lc3_row0_speed", row_speed[9:0],   256'd5);
                chk("lc3_row1_speed", row_speed[19:10], 256'd6);
                chk("lc3_row3_speed", row_speed[39:30], 256'd6);
                chk("lc3_row4_speed", row_speed[49:40], 256'd6);
            end
            if (i == 16) chk("lc_sat_row0_speed", row_speed[9:0], 256'd5);
        end

        // Restart from IDLE clears loop count
        sb.push_back(exp_for(0, 0));
        pulse_restart();
        repeat (7) @(negedge Clk);
        frame_commit();
        chk("restart_level",      level,          256'd0);
        chk("restart_row0_speed", row_speed[9:0], 256'd2);

        // Request during LOAD is held; a third during the chained load is dropped
        sb.push_back(exp_for(1, 0));
        sb.push_back(exp_for(2, 0));
        pulse_up();
        repeat (2) @(negedge Clk);
        pulse_up();
        repeat (6) @(negedge Clk);
        @(negedge Clk) frame_clk_rising_edge = 1'b1;
        @(negedge Clk) frame_clk_rising_edge = 1'b0;
        repeat (3) @(negedge Clk);
        chk("chained_busy", {255'd0, busy}, 256'd1);
        pulse_up();
        repeat (6) @(negedge Clk);
        frame_commit();
        repeat (3) @(negedge Clk);
        chk("drop_third_busy",  {255'd0, busy}, 256'd0);
        chk("drop_third_level", level,          256'd2);

        // Restart during WAIT_FRAME with target 2 aborts and reloads level 0
        sb.push_back(exp_for(0, 0));
        pulse_restart();
        repeat (7) @(negedge Clk);
        frame_commit();
        sb.push_back(exp_for(1, 0));
        pulse_up();
        repeat (7) @(negedge Clk);
        frame_commit();
        pulse_up();
        repeat (7) @(negedge Clk);
        chk("abort_busy", {255'd0, busy}, 256'd1);
        sb.push_back(exp_for(0, 0));
        @(negedge Clk) restart_req = 1'b1;
        @(negedge Clk) restart_req = 1'b0;
        chk("abort_rd_en", {255'd0, bus.cfg_rd_en}, 256'd1);
        chk("abort_addr0", bus.cfg_addr, 256'd0);
        for (int i = 1; i < 5; i++) begin
            @(negedge Clk);
            chk("abort_addr", bus.cfg_addr, 256'(i));
        end
        repeat (3) @(negedge Clk);
        frame_commit();
        chk("abort_level",      level,          256'd0);
        chk("abort_row0_speed", row_speed[9:0], 256'd2);

        // Simultaneous level-up and restart in IDLE: restart wins
        sb.push_back(exp_for(1, 0));
        pulse_up();
        repeat (7) @(negedge Clk);
        frame_commit();
        chk("pre_simul_level", level, 256'd1);
        sb.push_back(exp_for(0, 0));
        @(negedge Clk) begin level_up_req = 1'b1; restart_req = 1'b1; end
        @(negedge Clk) begin level_up_req = 1'b0; restart_req = 1'b0; end
        repeat (7) @(negedge Clk);
        frame_commit();
        chk("simul_level", level, 256'd0);

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 256'(sb.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
